// File: rtl/tmds_encoder_if.sv
// Pixel-side bus of one TMDS channel encoder: video byte, control pair,
// data-enable strobe in; 10-bit TMDS symbol out.
`timescale 1ns/1ps

interface tmds_encoder_if;
    logic [7:0] VD;    // video data byte
    logic [1:0] CD;    // control bits {C1,C0}, meaningful while VDE=0
    logic       VDE;   // 1 = encode VD, 0 = emit control symbol
    logic [9:0] TMDS;  // encoded symbol, bit 0 serialised first

    // Pixel source side
    modport master (
        output VD,
        output CD,
        output VDE,
        input  TMDS
    );

    // Encoder side
    modport slave (
        input  VD,
        input  CD,
        input  VDE,
        output TMDS
    );
endinterface : tmds_encoder_if

// File: rtl/tmds_encoder.sv
// Single-channel DVI/TMDS 8b/10b encoder. Stage 1 transition-minimises the
// byte into q_m[8:0]; stage 2 picks the DC-balancing polarity from the
// running disparity and emits the 10-bit symbol. Two-cycle latency, one
// symbol per pixel clock.
`timescale 1ns/1ps

module tmds_encoder (
    input  logic           pixclk,
    input  logic           rst,
    tmds_encoder_if.slave  bus
);

    // Control-period symbols, indexed by {C1,C0}
    localparam logic [9:0] CTRL_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_11 = 10'b1010101011;

    // Stage 1 state
    logic              vde_q;
    logic [1:0]        cd_q;
    logic [8:0]        qm_q;
    logic [8:0]        qm_d;

    // Stage 2 state
    logic [9:0]        tmds_q;
    logic [9:0]        tmds_d;
    logic signed [4:0] cnt_q;
    logic signed [4:0] cnt_d;

    // Intermediate terms
    logic [3:0]        vd_ones;
    logic              use_xnor;
    logic [3:0]        n1;
    logic [3:0]        n0;
    logic signed [4:0] diff;   // N1 - N0 of q_m[7:0]

    // Stage 1: choose XOR/XNOR chaining from the byte's ones count
    always_comb begin
        // NOTE: every output of a combinational block gets a value on every
        // path (defaults first), otherwise synthesis infers a latch.
        vd_ones = '0;
        qm_d    = '0;
        for (int i = 0; i < 8; i++) begin
            vd_ones = vd_ones + {3'b000, bus.VD[i]};
        end
        use_xnor = (vd_ones > 4'd4) || ((vd_ones == 4'd4) && !bus.VD[0]);
        qm_d[0]  = bus.VD[0];
        for (int i = 1; i < 8; i++) begin
            qm_d[i] = use_xnor ? ~(qm_d[i-1] ^ bus.VD[i]) : (qm_d[i-1] ^ bus.VD[i]);
        end
        qm_d[8] = ~use_xnor;
    end

    // Stage 2: pick symbol polarity and update running disparity
    always_comb begin
        n1 = '0;
        for (int i = 0; i < 8; i++) begin
            n1 = n1 + {3'b000, qm_q[i]};
        end
        n0     = 4'd8 - n1;
        diff   = $signed({1'b0, n1}) - $signed({1'b0, n0});
        tmds_d = CTRL_00;
        cnt_d  = cnt_q;

        if (!vde_q) begin
            // Blanking: fixed control symbol, disparity restarts at zero
            unique case (cd_q)
                2'b00:   tmds_d = CTRL_00;
                2'b01:   tmds_d = CTRL_01;
                2'b10:   tmds_d = CTRL_10;
                default: tmds_d = CTRL_11;
            endcase
            cnt_d = '0;
        end else if ((cnt_q == 5'sd0) || (n1 == n0)) begin
            // No bias to correct: q_m[8] alone decides the inversion
            tmds_d = {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
            cnt_d  = qm_q[8] ? (cnt_q + diff) : (cnt_q - diff);
        end else if (((cnt_q > 5'sd0) && (n1 > n0)) || ((cnt_q < 5'sd0) && (n0 > n1))) begin
            // Data would push disparity further the same way: invert it
            tmds_d = {1'b1, qm_q[8], ~qm_q[7:0]};
            cnt_d  = cnt_q + (qm_q[8] ? 5'sd2 : 5'sd0) - diff;
        end else begin
            // Data already pulls disparity back towards zero: send as-is
            tmds_d = {1'b0, qm_q[8], qm_q[7:0]};
            cnt_d  = cnt_q - (qm_q[8] ? 5'sd0 : 5'sd2) + diff;
        end
    end

    // Pipeline registers: stage 1 capture and stage 2 symbol/disparity
    always_ff @(posedge pixclk or posedge rst) begin
        // NOTE: clocked state uses non-blocking (<=) so every register
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            vde_q  <= 1'b0;
            cd_q   <= 2'b00;
            qm_q   <= '0;
            tmds_q <= CTRL_00;
            cnt_q  <= '0;
        end else begin
            vde_q  <= bus.VDE;
            cd_q   <= bus.CD;
            qm_q   <= qm_d;
            tmds_q <= tmds_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bus.TMDS = tmds_q;

endmodule : tmds_encoder

// File: tb/tb_tmds_encoder.sv
// Self-checking bench for tmds_encoder: directed DVI symbol sequences plus a
// long randomized run against a behavioural model that decides polarity
// from the running disparity and tracks disparity as ones-minus-zeros of
// each emitted word.
`timescale 1ns/1ps

module tb_tmds_encoder;

    typedef struct {
        logic [9:0] sym;
        bit         vde;
        int         cnt;
    } exp_t;

    logic pixclk = 1'b0;
    logic rst;
    tmds_encoder_if bus ();

    tmds_encoder dut (
        .pixclk (pixclk),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 pixclk = ~pixclk;

    int   n_checks = 0;
    int   n_errors = 0;
    int   model_cnt = 0;   // model running disparity
    int   out_disp  = 0;   // disparity measured from DUT output symbols
    exp_t exp_q[$];

    // Behavioural reference: one input triple -> expected symbol
    task automatic model_encode(input logic [7:0] vd, input logic [1:0] cd,
                                input logic vde, output logic [9:0] sym);
        logic [8:0] q;
        int         ones;
        int         bal;
        bit         xnor_mode;
        bit         invert;
        if (!vde) begin
            case (cd)
                2'b00:   sym = 10'h354;
                2'b01:   sym = 10'h0AB;
                2'b10:   sym = 10'h154;
                default: sym = 10'h2AB;
            endcase
            model_cnt = 0;
        end else begin
            ones      = $countones(vd);
            xnor_mode = (ones > 4) || (ones == 4 && vd[0] == 1'b0);
            q[0] = vd[0];
            for (int i = 1; i < 8; i++)
                q[i] = xnor_mode ? ~(q[i-1] ^ vd[i]) : (q[i-1] ^ vd[i]);
            q[8] = !xnor_mode;
            bal  = 2 * $countones(q[7:0]) - 8;
            if (model_cnt == 0 || bal == 0)
                invert = !q[8];
            else
                invert = ((model_cnt > 0) == (bal > 0));
            sym = {invert, q[8], invert ? ~q[7:0] : q[7:0]};
            model_cnt = model_cnt + 2 * $countones(sym) - 10;
        end
    endtask

    // Reset model and pipeline expectation after a reset release
    task automatic model_reset();
        exp_t e;
        exp_q.delete();
        e.sym = 10'h354; e.vde = 1'b0; e.cnt = 0;
        exp_q.push_back(e);
        model_cnt = 0;
        out_disp  = 0;
    endtask

    // Drive one input triple at the falling edge, advance one clock, and
    // return the symbol now on TMDS plus the model entry it belongs to.
    task automatic drive_cycle(input logic [7:0] vd, input logic [1:0] cd,
                               input logic vde, output logic [9:0] obs,
                               output exp_t e);
        exp_t n;
        bus.VD  = vd;
        bus.CD  = cd;
        bus.VDE = vde;
        model_encode(vd, cd, vde, n.sym);
        n.vde = vde;
        n.cnt = model_cnt;
        exp_q.push_back(n);
        @(posedge pixclk);
        @(negedge pixclk);
        obs = bus.TMDS;
        e   = exp_q.pop_front();
        if (e.vde) out_disp = out_disp + 2 * $countones(obs) - 10;
        else       out_disp = 0;
    endtask

    task automatic test_reset();
        logic [9:0] obs;
        exp_t       e;
        rst = 1'b1;
        bus.VD = 8'h00; bus.CD = 2'b00; bus.VDE = 1'b0;
        repeat (3) @(negedge pixclk);
        n_checks++;
        if (bus.TMDS !== 10'h354) begin
            n_errors++;
            $display("FAIL reset_hold: got %h want %h", bus.TMDS, 10'h354);
        end
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            drive_cycle(8'h00, 2'b00, 1'b0, obs, e);
            n_checks++;
            if (obs !== 10'h354) begin
                n_errors++;
                $display("FAIL reset_release[%0d]: got %h want %h", i, obs, 10'h354);
            end
        end
    endtask

    task automatic test_control();
        logic [9:0] obs;
        exp_t       e;
        logic [1:0] cds  [0:3];
        logic [9:0] want [0:2];
        cds  = '{2'b01, 2'b10, 2'b11, 2'b00};
        want = '{10'h0AB, 10'h154, 10'h2AB};
        for (int i = 0; i < 4; i++) begin
            drive_cycle(8'h5A, cds[i], 1'b0, obs, e);
            if (i > 0) begin
                n_checks++;
                if (obs !== want[i-1]) begin
                    n_errors++;
                    $display("FAIL control[%0d]: got %h want %h", i - 1, obs, want[i-1]);
                end
            end
        end
    endtask

    task automatic test_zero_run();
        logic [9:0] obs;
        exp_t       e;
        logic [9:0] want [0:9];
        int         cnt_want [0:9];
        want     = '{10'h100, 10'h3FF, 10'h100, 10'h3FF, 10'h100,
                     10'h3FF, 10'h100, 10'h3FF, 10'h100, 10'h100};
        cnt_want = '{-8, 2, -6, 4, -4, 6, -2, 8, 0, -8};
        drive_cycle(8'h00, 2'b00, 1'b0, obs, e);
        drive_cycle(8'h00, 2'b00, 1'b1, obs, e);
        for (int i = 0; i < 10; i++) begin
            drive_cycle(8'h00, 2'b00, 1'b1, obs, e);
            n_checks++;
            if (obs !== want[i]) begin
                n_errors++;
                $display("FAIL zero_run_sym[%0d]: got %h want %h", i, obs, want[i]);
            end
            n_checks++;
            if (out_disp != cnt_want[i]) begin
                n_errors++;
                $display("FAIL zero_run_cnt[%0d]: got %0d want %0d", i, out_disp, cnt_want[i]);
            end
        end
    endtask

    task automatic test_ff_run();
        logic [9:0] obs;
        exp_t       e;
        logic [9:0] want [0:3];
        int         cnt_want [0:3];
        want     = '{10'h200, 10'h0FF, 10'h0FF, 10'h200};
        cnt_want = '{-8, -2, 4, -4};
        drive_cycle(8'h00, 2'b00, 1'b0, obs, e);
        drive_cycle(8'hFF, 2'b00, 1'b1, obs, e);
        for (int i = 0; i < 4; i++) begin
            drive_cycle(8'hFF, 2'b00, 1'b1, obs, e);
            n_checks++;
            if (obs !== want[i]) begin
                n_errors++;
                $display("FAIL ff_run_sym[%0d]: got %h want %h", i, obs, want[i]);
            end
            n_checks++;
            if (out_disp != cnt_want[i]) begin
                n_errors++;
                $display("FAIL ff_run_cnt[%0d]: got %0d want %0d", i, out_disp, cnt_want[i]);
            end
        end
    endtask

    task automatic test_blanking();
        logic [9:0] obs;
        exp_t       e;
        logic       vdes [0:4];
        logic [9:0] want [0:3];
        vdes = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        want = '{10'h100, 10'h3FF, 10'h354, 10'h100};
        drive_cycle(8'h00, 2'b00, 1'b0, obs, e);
        for (int i = 0; i < 5; i++) begin
            drive_cycle(8'h00, 2'b00, vdes[i], obs, e);
            if (i > 0) begin
                n_checks++;
                if (obs !== want[i-1]) begin
                    n_errors++;
                    $display("FAIL blanking[%0d]: got %h want %h", i - 1, obs, want[i-1]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] obs;
        exp_t       e;
        logic       vdes [0:5];
        logic [1:0] cds  [0:5];
        logic [9:0] want [0:4];
        vdes = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        cds  = '{2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b00};
        want = '{10'h100, 10'h154, 10'h100, 10'h0AB, 10'h100};
        drive_cycle(8'h00, 2'b00, 1'b0, obs, e);
        for (int i = 0; i < 6; i++) begin
            drive_cycle(8'h00, cds[i], vdes[i], obs, e);
            if (i > 0) begin
                n_checks++;
                if (obs !== want[i-1]) begin
                    n_errors++;
                    $display("FAIL toggle[%0d]: got %h want %h", i - 1, obs, want[i-1]);
                end
            end
        end
    endtask

    task automatic test_random(input int cycles);
        logic [9:0] obs;
        exp_t       e;
        logic [7:0] vd;
        logic [1:0] cd;
        logic       vde;
        for (int i = 0; i < cycles; i++) begin
            vd  = 8'($urandom);
            cd  = 2'($urandom);
            vde = ($urandom_range(0, 3) != 0);
            drive_cycle(vd, cd, vde, obs, e);
            n_checks++;
            if (obs !== e.sym) begin
                n_errors++;
                $display("FAIL random_sym[%0d]: got %h want %h", i, obs, e.sym);
            end
            if (e.vde) begin
                n_checks++;
                if (out_disp != e.cnt) begin
                    n_errors++;
                    $display("FAIL random_cnt[%0d]: got %0d want %0d", i, out_disp, e.cnt);
                end
                n_checks++;
                if (out_disp > 10 || out_disp < -10) begin
                    n_errors++;
                    $display("FAIL random_bound[%0d]: got %0d want within -10..10", i, out_disp);
                end
            end
        end
    endtask

    task automatic test_reset_midstream();
        logic [9:0] obs;
        exp_t       e;
        logic [9:0] want [0:3];
        want = '{10'h354, 10'h100, 10'h3FF, 10'h100};
        // Leave cnt at -8 with another 0x00 still in stage 1
        drive_cycle(8'h00, 2'b00, 1'b0, obs, e);
        drive_cycle(8'h00, 2'b00, 1'b1, obs, e);
        drive_cycle(8'h00, 2'b00, 1'b1, obs, e);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (bus.TMDS !== 10'h354) begin
            n_errors++;
            $display("FAIL reset_async: got %h want %h", bus.TMDS, 10'h354);
        end
        @(posedge pixclk);
        @(negedge pixclk);
        n_checks++;
        if (bus.TMDS !== 10'h354) begin
            n_errors++;
            $display("FAIL reset_held: got %h want %h", bus.TMDS, 10'h354);
        end
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            drive_cycle(8'h00, 2'b00, 1'b1, obs, e);
            n_checks++;
            if (obs !== want[i]) begin
                n_errors++;
                $display("FAIL reset_resume[%0d]: got %h want %h", i, obs, want[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_control();
        test_zero_run();
        test_ff_run();
        test_blanking();
        test_back_to_back();
        test_random(20000);
        test_reset_midstream();
        test_random(2000);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Run-time bound in case the clock or a task stalls
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_tmds_encoder
